// File: rtl/rx_uart.sv
// rx_uart: 16x oversampled UART receiver.
// Frame: start bit (0), NB_DATA data bits LSB first, N_STOP stop bits (1).
// An internal divider produces one oversample tick every DVSR clocks.
// Optional stop-bit checking and the o_frame_err output are enabled by
// defining the macro RX_UART_FRAME_ERR_EN.
module rx_uart #(
  parameter int unsigned NB_DATA       = 8,
  parameter int unsigned N_STOP        = 2,
  parameter int unsigned NB_STATE      = 2,
  parameter int unsigned NB_COUNT      = 4,
  parameter int unsigned NB_DATA_COUNT = 3,
  parameter int unsigned DVSR          = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic               rx_done_tick,
  output logic [NB_DATA-1:0] o_data
`ifdef RX_UART_FRAME_ERR_EN
  ,
  output logic               o_frame_err
`endif
);

  typedef enum logic [NB_STATE-1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  localparam logic [15:0]              DvsrLast = 16'(DVSR - 1);
  // Mid-bit tick (7 for 16x oversampling) and last tick of a bit (15).
  localparam logic [NB_COUNT-1:0]      TickMid  = {1'b0, {(NB_COUNT - 1){1'b1}}};
  localparam logic [NB_COUNT-1:0]      TickLast = '1;
  localparam logic [NB_DATA_COUNT-1:0] DataLast = NB_DATA_COUNT'(NB_DATA - 1);
  localparam logic [NB_DATA_COUNT-1:0] StopLast = NB_DATA_COUNT'(N_STOP - 1);

  logic                     rx_meta_q;
  logic                     rx_sync_q;
  logic [15:0]              div_q;
  logic                     s_tick;
  state_e                   state_q;
  logic [NB_COUNT-1:0]      tick_q;
  logic [NB_DATA_COUNT-1:0] bit_q;
  logic [NB_DATA-1:0]       shift_q;
`ifdef RX_UART_FRAME_ERR_EN
  logic                     err_q;
`endif

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Oversample tick divider; with DVSR=1 the counter stays at 0 and s_tick is always high.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      div_q <= '0;
    end else if (s_tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

  assign s_tick = (div_q == DvsrLast);

  // Receive FSM with registered done pulse, data and frame-error outputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_done_tick <= 1'b0;
      o_data       <= '0;
`ifdef RX_UART_FRAME_ERR_EN
      err_q        <= 1'b0;
      o_frame_err  <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
`ifdef RX_UART_FRAME_ERR_EN
      o_frame_err  <= 1'b0;
`endif
      case (state_q)
        // Leave idle on any clock the line is low, not only on a tick.
        StIdle: begin
          if (!rx_sync_q) begin
            state_q <= StStart;
            tick_q  <= '0;
          end
        end
        StStart: begin
          if (s_tick) begin
            if (tick_q == TickMid) begin
              tick_q  <= '0;
              bit_q   <= '0;
              // A high line at mid start bit is a glitch: drop it silently.
              state_q <= rx_sync_q ? StIdle : StData;
            end else begin
              tick_q <= tick_q + NB_COUNT'(1);
            end
          end
        end
        StData: begin
          if (s_tick) begin
            if (tick_q == TickLast) begin
              tick_q  <= '0;
              shift_q <= {rx_sync_q, shift_q[NB_DATA-1:1]};
              if (bit_q == DataLast) begin
                state_q <= StStop;
                bit_q   <= '0;
`ifdef RX_UART_FRAME_ERR_EN
                err_q   <= 1'b0;
`endif
              end else begin
                bit_q <= bit_q + NB_DATA_COUNT'(1);
              end
            end else begin
              tick_q <= tick_q + NB_COUNT'(1);
            end
          end
        end
        StStop: begin
          // Sampling was aligned to mid-bit in StStart, so the last tick of each
          // stop-bit period here lands in the middle of that stop bit on the line.
          if (s_tick) begin
            if (tick_q == TickLast) begin
              tick_q <= '0;
`ifdef RX_UART_FRAME_ERR_EN
              err_q  <= err_q | ~rx_sync_q;
`endif
              if (bit_q == StopLast) begin
                state_q      <= StIdle;
                rx_done_tick <= 1'b1;
                o_data       <= shift_q;
`ifdef RX_UART_FRAME_ERR_EN
                o_frame_err  <= err_q | ~rx_sync_q;
                err_q        <= 1'b0;
`endif
              end else begin
                bit_q <= bit_q + NB_DATA_COUNT'(1);
              end
            end else begin
              tick_q <= tick_q + NB_COUNT'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: directed vector table, randomized frames against
// a byte/latency reference model, and a DVSR=4 instance.
module tb_rx_uart;

`ifdef RX_UART_FRAME_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx_a;
  logic       rx_b;
  logic       done_a;
  logic       done_b;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       err_a;
  logic       err_b;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  rx_uart #(.DVSR(1)) dut_a (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_rx        (rx_a),
    .rx_done_tick(done_a),
    .o_data      (data_a)
`ifdef RX_UART_FRAME_ERR_EN
    ,
    .o_frame_err (err_a)
`endif
  );

  rx_uart #(.DVSR(4)) dut_b (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_rx        (rx_b),
    .rx_done_tick(done_b),
    .o_data      (data_b)
`ifdef RX_UART_FRAME_ERR_EN
    ,
    .o_frame_err (err_b)
`endif
  );

`ifndef RX_UART_FRAME_ERR_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulses observed on the DUTs, recorded away from the active edge.
  logic [7:0] ga_data[$];
  int         ga_cyc[$];
  bit         ga_err[$];
  logic [7:0] gb_data[$];
  int         gb_cyc[$];

  always @(negedge clk) begin
    if (done_a) begin
      ga_data.push_back(data_a);
      ga_cyc.push_back(cyc);
      ga_err.push_back(err_a);
    end
    if (done_b) begin
      gb_data.push_back(data_b);
      gb_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // All drive tasks start and finish 1 time unit after a rising edge.
  task automatic idle(input int n);
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Plays one frame (start, 8 data LSB first, 2 stop) with cpb clocks per bit.
  // abort_at >= 0 stops driving after that many clocks.
  task automatic play(input bit sel_b, input logic [7:0] d, input int cpb, input bit stop0_low,
                      input int abort_at, output int start_cyc);
    logic [10:0] bits;
    bits      = {1'b1, ~stop0_low, d, 1'b0};
    start_cyc = cyc;
    for (int c = 0; c < 11 * cpb; c++) begin
      if (c == abort_at) break;
      if (sel_b) rx_b = bits[c / cpb];
      else rx_a = bits[c / cpb];
      @(posedge clk);
      #1;
    end
  endtask

  typedef enum int {VFrame, VGlitch, VAbort} vkind_e;
  typedef struct {
    vkind_e     kind;
    logic [7:0] data;
    bit         stop0_low;
    int         gap;
    bit         exp_pulse;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_odata;
  int         st;
  int         lat;
  logic [7:0] rbyte;

  initial begin
    vecs[0] = '{VFrame,  8'hA5, 1'b0, 20, 1'b1};
    vecs[1] = '{VFrame,  8'h3C, 1'b0, 0,  1'b1};
    vecs[2] = '{VFrame,  8'hFF, 1'b0, 0,  1'b1};
    vecs[3] = '{VGlitch, 8'h00, 1'b0, 30, 1'b0};
    vecs[4] = '{VAbort,  8'h81, 1'b0, 10, 1'b0};
    vecs[5] = '{VFrame,  8'h5A, 1'b0, 20, 1'b1};
    vecs[6] = '{VFrame,  8'h77, 1'b1, 5,  1'b1};

    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done_a", done_a, 0);
    check("reset_data_a", data_a, 0);
    check("reset_err_a", err_a, 0);
    check("reset_done_b", done_b, 0);
    check("reset_data_b", data_b, 0);
    check("reset_state_a", 32'(dut_a.state_q), 0);
    rst_n     = 1'b1;
    exp_odata = 8'h00;

    for (int i = 0; i < 7; i++) begin
      idle(vecs[i].gap);
      case (vecs[i].kind)
        VFrame: begin
          play(1'b0, vecs[i].data, 16, vecs[i].stop0_low, -1, st);
          exp_odata = vecs[i].data;
        end
        VGlitch: begin
          rx_a = 1'b0;
          repeat (4) begin
            @(posedge clk);
            #1;
          end
          idle(40);
          check("glitch_state_idle", 32'(dut_a.state_q), 0);
        end
        default: begin
          play(1'b0, vecs[i].data, 16, 1'b0, 50, st);
          rx_a  = 1'b1;
          rst_n = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          exp_odata = 8'h00;
          idle(200);
          check("abort_state_idle", 32'(dut_a.state_q), 0);
        end
      endcase
      check($sformatf("vec%0d_pulses", i), ga_data.size(), vecs[i].exp_pulse ? 1 : 0);
      if (vecs[i].exp_pulse && ga_data.size() > 0) begin
        check($sformatf("vec%0d_pulse_data", i), ga_data[0], vecs[i].data);
        // Latency counted from the synchronized falling edge (2 clocks after drive).
        lat = ga_cyc[0] - (st + 2);
        check_range($sformatf("vec%0d_latency", i), lat, 167, 169);
        check($sformatf("vec%0d_frame_err", i), ga_err[0], ErrEn && vecs[i].stop0_low);
      end
      check($sformatf("vec%0d_o_data", i), data_a, exp_odata);
      ga_data.delete();
      ga_cyc.delete();
      ga_err.delete();
    end

    // Random bytes with random idle gaps (0 = back-to-back).
    for (int i = 0; i < 16; i++) begin
      rbyte = 8'($urandom_range(0, 255));
      idle(int'($urandom_range(0, 8)));
      play(1'b0, rbyte, 16, 1'b0, -1, st);
      check($sformatf("rnd%0d_pulses", i), ga_data.size(), 1);
      if (ga_data.size() > 0) begin
        check($sformatf("rnd%0d_data", i), ga_data[0], rbyte);
        lat = ga_cyc[0] - (st + 2);
        check_range($sformatf("rnd%0d_latency", i), lat, 167, 169);
        check($sformatf("rnd%0d_frame_err", i), ga_err[0], 0);
      end
      check($sformatf("rnd%0d_o_data", i), data_a, rbyte);
      ga_data.delete();
      ga_cyc.delete();
      ga_err.delete();
    end

    // DVSR=4 instance: 64 clocks per bit, 168 ticks of 4 clocks each.
    idle(10);
    check("dvsr4_no_early_pulse", gb_data.size(), 0);
    play(1'b1, 8'h01, 64, 1'b0, -1, st);
    idle(10);
    check("dvsr4_pulses", gb_data.size(), 1);
    if (gb_data.size() > 0) begin
      check("dvsr4_pulse_data", gb_data[0], 8'h01);
      lat = gb_cyc[0] - (st + 2);
      check_range("dvsr4_latency", lat, 667, 677);
    end
    check("dvsr4_o_data", data_b, 8'h01);
    check("dvsr4_a_quiet", ga_data.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
